// File: rtl/par_pkg.sv
// Shared definitions for the serial framing path: serializer state encoding,
// default frame width and the parity-mode constants that the downstream
// serial parity detector also uses.
package par_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } ser_state_t;

  localparam int DEF_WIDTH = 8;

  // Parity-mode selectors; the detector must use the same encoding.
  localparam logic EVEN_PAR = 1'b0;
  localparam logic ODD_PAR  = 1'b1;

endpackage : par_pkg

// File: rtl/par_serializer.sv
// Parallel-to-serial framer. Takes a WIDTH-bit word on a valid/ready
// handshake, shifts it out LSB-first one bit per cycle, then appends one
// parity bit. In even mode a running-parity detector that starts at EVEN
// returns to EVEN at every frame boundary. A new word may be accepted while
// the parity bit is on the line, so frames can run back-to-back.
module par_serializer
  import par_pkg::ser_state_t, par_pkg::IDLE, par_pkg::DATA, par_pkg::PAR;
#(
  parameter int   WIDTH   = par_pkg::DEF_WIDTH,
  parameter logic ODD_PAR = par_pkg::EVEN_PAR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sr_out,
  output logic             sr_vld,
  output logic             sr_last,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Frame state
  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             par_q,   par_d;

  // Output flops, loaded from the next-state values so every serial output
  // leaves a register and lines up with the state it describes.
  logic din_ready_q, din_ready_d;
  logic sr_out_q,    sr_out_d;
  logic sr_vld_q,    sr_vld_d;
  logic sr_last_q,   sr_last_d;
  logic busy_q,      busy_d;

  logic accept_s;

  assign accept_s = din_valid && din_ready_q;

  // Next-state logic for the FSM and the shift/count/parity datapath.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = DATA;
          shreg_d = din;
          cnt_d   = {CNT_W{1'b0}};
          par_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        par_d   = par_q ^ shreg_q[0];
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          // Hold the count at its last value instead of wrapping.
          state_d = PAR;
          cnt_d   = cnt_q;
        end else begin
          state_d = DATA;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      PAR: begin
        if (accept_s) begin
          // Reload directly so the next frame follows the parity bit.
          state_d = DATA;
          shreg_d = din;
          cnt_d   = {CNT_W{1'b0}};
          par_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        par_d   = 1'b0;
      end
    endcase
  end

  // Decode the outputs that the next state will present.
  always_comb begin
    din_ready_d = 1'b1;
    sr_out_d    = 1'b0;
    sr_vld_d    = 1'b0;
    sr_last_d   = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      IDLE: begin
        din_ready_d = 1'b1;
      end
      DATA: begin
        din_ready_d = 1'b0;
        sr_out_d    = shreg_d[0];
        sr_vld_d    = 1'b1;
        busy_d      = 1'b1;
      end
      PAR: begin
        din_ready_d = 1'b1;
        sr_out_d    = par_d ^ ODD_PAR;
        sr_vld_d    = 1'b1;
        sr_last_d   = 1'b1;
        busy_d      = 1'b1;
      end
      default: begin
        din_ready_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      par_q       <= 1'b0;
      din_ready_q <= 1'b1;
      sr_out_q    <= 1'b0;
      sr_vld_q    <= 1'b0;
      sr_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      din_ready_q <= din_ready_d;
      sr_out_q    <= sr_out_d;
      sr_vld_q    <= sr_vld_d;
      sr_last_q   <= sr_last_d;
      busy_q      <= busy_d;
    end
  end

  assign din_ready = din_ready_q;
  assign sr_out    = sr_out_q;
  assign sr_vld    = sr_vld_q;
  assign sr_last   = sr_last_q;
  assign busy      = busy_q;

endmodule : par_serializer

// File: doc/par_serializer.md
# par_serializer

Parallel-to-serial framer that feeds the serial parity detector. Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out LSB-first, one bit per cycle, then appends one parity bit. In even mode each frame has even total parity, so a downstream running-parity detector that starts in EVEN returns to EVEN at every frame boundary.

## Interface
- WIDTH, default 8: data bits per frame, ≥2.
- ODD_PAR, default 0: 0 selects even parity, 1 selects odd parity.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  parallel word. Sampled only on an accept.
- din_valid  in  1  din holds a word.
- din_ready  out  1  block can accept a word this cycle.
- sr_out  out  1  serial bit, connects to the detector's serial input.
- sr_vld  out  1  sr_out carries a frame bit.
- sr_last  out  1  sr_out is the parity bit, the last bit of the frame.
- busy  out  1  a frame is in progress (DATA or PAR).

## Operation
- States: IDLE, DATA, PAR. This is a Moore FSM. All serial outputs come from registers: shift register, state, and parity accumulator.
- Accept = din_valid && din_ready.
- din_ready = 1 in IDLE, 1 in PAR, 0 in DATA.
- **IDLE:**
  - sr_vld=0, sr_last=0, sr_out=0.
  - On accept: shreg←din, cnt←0, par←0, go to DATA.
- **DATA:**
  - sr_out=shreg[0], sr_vld=1.
  - Each cycle: par←par^shreg[0], shreg←shreg>>1, cnt←cnt+1.
  - When cnt==WIDTH-1, go to PAR.
- **PAR:**
  - sr_out = par ^ ODD_PAR, sr_vld=1, sr_last=1.
  - On accept: load as in IDLE and go to DATA, giving back-to-back frames with no gap.
  - Otherwise go to IDLE.
- Parity bit value:
  - Even mode: XOR of all data bits.
  - Odd mode: its inverse.
  - The frame's total count of ones is even or odd respectively.
- cnt width is $clog2(WIDTH). It never wraps past WIDTH-1 because the state leaves DATA at WIDTH-1.
- din_valid and din changes while din_ready=0 are ignored. No input buffering.
- sr_out is forced to 0 whenever sr_vld=0.

## Timing
- Reset (async assert, any state): state=IDLE, shreg=0, cnt=0, par=0.
  - Outputs: din_ready=1, sr_out=0, sr_vld=0, sr_last=0, busy=0.
  - Any frame in progress is discarded. No partial parity bit is emitted.
- Accept at clock edge k:
  - Data bit 0 appears on sr_out in the cycle after edge k.
  - Bit i appears in the cycle after edge k+i.
  - The parity bit appears in the cycle after edge k+WIDTH.
- Frame length is WIDTH+1 cycles. Sustained throughput is one word per WIDTH+1 cycles.
- Accept in PAR: the first bit of the next frame directly follows the parity bit.
- busy = (state != IDLE), registered.

## Structure
- Package par_pkg holds:
  - typedef enum logic [1:0] {IDLE, DATA, PAR} ser_state_t;
  - localparam default WIDTH;
  - EVEN_PAR/ODD_PAR constants. The parity detector shares these constants.
- No sub-module is needed. A single module contains the state register, the shift/count/parity registers, and combinational next-state logic.

## Test plan
- **Reset values:** assert rst low mid-run → din_ready=1 and sr_vld=sr_last=sr_out=busy=0 immediately. They stay so after release until an accept.
- **Even frame:** WIDTH=8, ODD_PAR=0, single accept of 8'hA5.
  - Expect sr_out = 1,0,1,0,0,1,0,1 (sr_vld=1, sr_last=0), then 0 with sr_last=1, then IDLE.
  - The chained parity detector output reads 0 after the frame.
- **Odd frame:** ODD_PAR=1, accept 8'h01 → bits 1,0,0,0,0,0,0,0 then parity bit 0, for a total of one 1.
- **Back-to-back:** din_valid held high with 8'hFF then 8'h80.
  - Expect 18 consecutive sr_vld=1 cycles.
  - Parity bits are 0 (for 8'hFF) and 1 (for 8'h80).
  - din_ready=1 only in IDLE/PAR cycles.
- **Blocked input:** din_valid=1 with din changing every cycle during DATA → the serialized bits match only the word captured at the accept.
- **Reset mid-frame:** assert rst after 3 data bits of 8'h3C → outputs 0 at once, no sr_last pulse. After release, accepting 8'h0F produces a clean frame with parity bit 0.
